out_port_buffer: RTL and testbench
==================================

// Module: out_port_buffer
// PURPOSE
//  Producer end of the CPU output interface: drives outFlag/out toward the bench/host.
//  Pipeline writeback pushes OUT-instruction results into a small FIFO.
//  Each buffered word is emitted as a one-cycle outFlag strobe on the 25-bit out bus.
//  Emission is paced by out_ready and a programmable inter-word gap.
//  full stalls the pipeline so no result is lost.
// PARAMETERS
//  DATAWIDTH  25  width of out / wr_data
//  DEPTH       4  FIFO entries (power of two, >=2)
//  ADDRWIDTH   2  log2(DEPTH)
//  GAP         0  minimum idle cycles between consecutive outFlag strobes (0..15)
// PORTS
//  clock     in   1          rising-edge clock
//  reset     in   1          asynchronous, active-high reset
//  wr_en     in   1          writeback stage presents an OUT result this cycle
//  wr_data   in   DATAWIDTH  value to output
//  out_ready in   1          consumer accepts a strobe this cycle
//  full      out  1          FIFO holds DEPTH entries; pipeline must stall OUT writeback
//  overflow  out  1          sticky: a push was dropped
//  outFlag   out  1          out carries a new word this cycle (one-cycle strobe)
//  out       out  DATAWIDTH  emitted word; holds last value while outFlag=0
// BEHAVIOUR
//  Reset (async, immediate): count=0, rd/wr ptr=0, out=0, outFlag=0, full=0,
//   overflow=0, gap counter=0, state=IDLE. Reset mid-transfer discards all FIFO contents.
//  FIFO: count 0..DEPTH. full = (count==DEPTH), registered from count.
//   Pointers wrap modulo DEPTH.
//  pop  = (state==IDLE) && count!=0 && out_ready.
//  push = wr_en && (count<DEPTH || pop).
//   Simultaneous push+pop when full is accepted; count stays DEPTH.
//   Simultaneous push+pop when count==1: the popped word is the old entry; count stays 1.
//  wr_en while full with no pop: word dropped, overflow<=1 (cleared only by reset).
//  Emission: on the edge where pop is true, out<=mem[rd_ptr] and outFlag<=1.
//   outFlag is high for exactly that following cycle, then low.
//  Latency: a word pushed into an empty FIFO at edge N (out_ready=1, IDLE)
//   appears with outFlag=1 after edge N+1.
//  States:
//   IDLE: if pop -> (GAP==0 ? IDLE : WAIT), with gap counter<=GAP.
//   WAIT: outFlag<=0, gap counter decrements each cycle; at 1 -> IDLE.
//  With GAP=0, back-to-back strobes occur every cycle while data and out_ready are present.
//  out_ready=0: no pop and outFlag<=0. out is held; FIFO still accepts pushes.
//  Arithmetic: count is ADDRWIDTH+1 bits. Gap counter is 4 bits. No truncation of data.
// TESTING
//  1. Reset, push 0x0000005, out_ready=1 -> outFlag=1 with out=0x0000005 exactly
//     2 edges after push; outFlag=0 next cycle.
//  2. Push 1,2,3,4,5 on consecutive cycles, out_ready=0 -> full=1 after the 4th push;
//     5th dropped, overflow=1. Then out_ready=1 -> strobes 1,2,3,4 on 4 consecutive
//     cycles, then empty.
//  3. GAP=2, push 0xA,0xB,0xC -> strobes spaced 3 cycles apart: A@t, B@t+3, C@t+6.
//  4. Full FIFO with out_ready=1 and wr_en=1 every cycle -> full stays 1, no overflow,
//     strobe every cycle, outputs in push order.
//  5. Assert reset mid-stream with 3 words queued -> outFlag, out, count and full go to 0
//     immediately; no further strobes after release until a new push.
//  6. Push 0x1FFFFFF -> out=0x1FFFFFF (all 25 bits). out_ready toggling 1/0 -> strobes
//     only in ready cycles; out held between strobes.

Source files
------------

// File: rtl/out_port_buffer.sv
// Output-port FIFO: buffers OUT writeback results and emits each one as a
// single-cycle outFlag strobe, paced by out_ready and a programmable gap.
module out_port_buffer #(
   parameter int DATAWIDTH = 25,
   parameter int DEPTH     = 4,
   parameter int ADDRWIDTH = 2,
   parameter int GAP       = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [DATAWIDTH-1:0] wr_data,
   input  logic                 out_ready,
   output logic                 full,
   output logic                 overflow,
   output logic                 outFlag,
   output logic [DATAWIDTH-1:0] out
);

   localparam int CW = ADDRWIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [3:0]    GAP_C   = 4'(GAP);
   localparam bit            HAS_GAP = (GAP != 0);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic [ADDRWIDTH-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [3:0]             gap_q, gap_d;
   logic                   full_q, full_d, ovf_q, ovf_d, flag_q, flag_d;
   logic [DATAWIDTH-1:0]   out_q, out_d;
   logic [DATAWIDTH-1:0]   mem_q [DEPTH];
   logic                   pop, push;

   always_comb begin
      pop      = (state_q == IDLE) && (count_q != '0) && out_ready;
      // A push into a full FIFO is still accepted when a pop frees a slot.
      push     = wr_en && ((count_q < DEPTH_C) || pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      full_d   = (count_d == DEPTH_C);
      ovf_d    = ovf_q | (wr_en & ~push);
      flag_d   = pop;
      out_d    = pop ? mem_q[rd_ptr_q] : out_q;
      state_d  = state_q;
      gap_d    = gap_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               gap_d = GAP_C;
               if (HAS_GAP) state_d = WAIT;
            end
         end
         WAIT: begin
            gap_d = gap_q - 1'b1;
            if (gap_q <= 4'd1) begin
               state_d = IDLE;
               gap_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gap_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         gap_q    <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         flag_q   <= 1'b0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         gap_q    <= gap_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         flag_q   <= flag_d;
         out_q    <= out_d;
      end
   end

   // Storage needs no reset: count/pointers define which entries are valid.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign full     = full_q;
   assign overflow = ovf_q;
   assign outFlag  = flag_q;
   assign out      = out_q;

endmodule

// File: tb/tb_out_port_buffer.sv
// Scoreboard bench for out_port_buffer: GAP=0 instance for most scenarios,
// GAP=2 instance for strobe spacing.
module tb_out_port_buffer;

   logic        clock, reset;
   logic        wr_en, rdy, full, ovf, flag;
   logic [24:0] wr_data, out;
   logic        wr_en1, rdy1, full1, ovf1, flag1;
   logic [24:0] wr_data1, out1;

   int total = 0;
   int bad   = 0;
   logic [24:0] sbq[$];
   logic [24:0] sbq1[$];
   logic [24:0] exp_w;

   out_port_buffer #(.DATAWIDTH(25), .DEPTH(4), .ADDRWIDTH(2), .GAP(0)) dut0 (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .out_ready(rdy),
      .full(full), .overflow(ovf), .outFlag(flag), .out(out));

   out_port_buffer #(.DATAWIDTH(25), .DEPTH(4), .ADDRWIDTH(2), .GAP(2)) dut1 (
      .clock(clock), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1), .out_ready(rdy1),
      .full(full1), .overflow(ovf1), .outFlag(flag1), .out(out1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (flag !== 1'b0) begin bad++; $display("FAIL rst_flag: got %b want 0", flag); end
      total++; if (out !== 25'd0) begin bad++; $display("FAIL rst_out: got %h want 0", out); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", full); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
      total++; if (flag1 !== 1'b0) begin bad++; $display("FAIL rst_flag1: got %b want 0", flag1); end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_single();
      wr_en = 1'b1; wr_data = 25'h0000005; rdy = 1'b1; sbq.push_back(25'h0000005);
      cyc();
      wr_en = 1'b0;
      total++; if (flag !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", flag); end
      cyc();
      exp_w = sbq.pop_front();
      total++; if (flag !== 1'b1) begin bad++; $display("FAIL single_flag: got %b want 1", flag); end
      total++; if (out !== exp_w) begin bad++; $display("FAIL single_out: got %h want %h", out, exp_w); end
      cyc();
      total++; if (flag !== 1'b0) begin bad++; $display("FAIL single_drop: got %b want 0", flag); end
      total++; if (out !== 25'h5) begin bad++; $display("FAIL single_hold: got %h want 5", out); end
   endtask

   task automatic test_full_overflow();
      rdy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1'b1; wr_data = 25'(i);
         if (i <= 4) sbq.push_back(25'(i));
         cyc();
         if (i == 4) begin
            total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full4: got %b want 1", full); end
            total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", ovf); end
         end
         if (i == 5) begin
            total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
            total++; if (flag !== 1'b0) begin bad++; $display("FAIL ovf_noflag: got %b want 0", flag); end
         end
      end
      wr_en = 1'b0; rdy = 1'b1;
      cyc();
      for (int j = 0; j < 4; j++) begin
         exp_w = (sbq.size() != 0) ? sbq.pop_front() : 25'h1ffffff;
         total++; if (flag !== 1'b1) begin bad++; $display("FAIL drain_flag%0d: got %b want 1", j, flag); end
         total++; if (out !== exp_w) begin bad++; $display("FAIL drain_out%0d: got %h want %h", j, out, exp_w); end
         cyc();
      end
      total++; if (flag !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", flag); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL drain_full: got %b want 0", full); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
   endtask

   task automatic test_gap();
      int n;
      int t[3];
      n = 0;
      rdy1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         wr_en1 = (c < 3);
         wr_data1 = 25'hA + 25'(c);
         if (c < 3) sbq1.push_back(25'hA + 25'(c));
         cyc();
         if (flag1) begin
            if (n < 3) t[n] = c;
            exp_w = (sbq1.size() != 0) ? sbq1.pop_front() : 25'h1ffffff;
            total++; if (out1 !== exp_w) begin bad++; $display("FAIL gap_out%0d: got %h want %h", n, out1, exp_w); end
            n++;
         end
      end
      wr_en1 = 1'b0;
      total++; if (n !== 3) begin bad++; $display("FAIL gap_count: got %0d want 3", n); end
      if (n == 3) begin
         total++; if (t[1] - t[0] !== 3) begin bad++; $display("FAIL gap_ab: got %0d want 3", t[1] - t[0]); end
         total++; if (t[2] - t[1] !== 3) begin bad++; $display("FAIL gap_bc: got %0d want 3", t[2] - t[1]); end
      end
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 25'h10 + 25'(i); sbq.push_back(25'h10 + 25'(i));
         cyc();
      end
      rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 25'h14 + 25'(i); sbq.push_back(25'h14 + 25'(i));
         cyc();
         exp_w = sbq.pop_front();
         total++; if (full !== 1'b1) begin bad++; $display("FAIL b2b_full%0d: got %b want 1", i, full); end
         total++; if (ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf%0d: got %b want 0", i, ovf); end
         total++; if (flag !== 1'b1) begin bad++; $display("FAIL b2b_flag%0d: got %b want 1", i, flag); end
         total++; if (out !== exp_w) begin bad++; $display("FAIL b2b_out%0d: got %h want %h", i, out, exp_w); end
      end
      wr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         exp_w = (sbq.size() != 0) ? sbq.pop_front() : 25'h1ffffff;
         total++; if (flag !== 1'b1) begin bad++; $display("FAIL b2b_tflag%0d: got %b want 1", i, flag); end
         total++; if (out !== exp_w) begin bad++; $display("FAIL b2b_tout%0d: got %h want %h", i, out, exp_w); end
      end
      cyc();
      total++; if (flag !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", flag); end
   endtask

   task automatic test_reset_mid();
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 25'h100 + 25'(i);
         cyc();
      end
      rdy = 1'b1; wr_data = 25'h104;
      cyc();
      wr_en = 1'b0;
      total++; if (out !== 25'h100) begin bad++; $display("FAIL mid_pre: got %h want 100", out); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (flag !== 1'b0) begin bad++; $display("FAIL mid_flag: got %b want 0", flag); end
      total++; if (out !== 25'd0) begin bad++; $display("FAIL mid_out: got %h want 0", out); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL mid_full: got %b want 0", full); end
      #1;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         total++; if (flag !== 1'b0) begin bad++; $display("FAIL mid_quiet%0d: got %b want 0", i, flag); end
      end
      wr_en = 1'b1; wr_data = 25'h123; sbq.push_back(25'h123);
      cyc();
      wr_en = 1'b0;
      cyc();
      exp_w = sbq.pop_front();
      total++; if (flag !== 1'b1 || out !== exp_w) begin
         bad++; $display("FAIL mid_after: got flag=%b out=%h want 1/%h", flag, out, exp_w);
      end
   endtask

   task automatic test_wide_toggle();
      logic [24:0] last;
      logic        r;
      last = 25'h123;
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1;
         wr_data = (i == 0) ? 25'h1FFFFFF : (i == 1) ? 25'h0AAAAAA : 25'h1555555;
         sbq.push_back(wr_data);
         cyc();
      end
      wr_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         r = (k % 2 == 0);
         rdy = r;
         cyc();
         if (r && sbq.size() != 0) begin
            last = sbq.pop_front();
            total++; if (flag !== 1'b1 || out !== last) begin
               bad++; $display("FAIL tog_strobe%0d: got flag=%b out=%h want 1/%h", k, flag, out, last);
            end
         end else begin
            total++; if (flag !== 1'b0 || out !== last) begin
               bad++; $display("FAIL tog_hold%0d: got flag=%b out=%h want 0/%h", k, flag, out, last);
            end
         end
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      wr_en = 1'b0; wr_data = '0; rdy = 1'b0;
      wr_en1 = 1'b0; wr_data1 = '0; rdy1 = 1'b0;
      #12;
      test_reset();
      test_single();
      test_full_overflow();
      test_gap();
      test_back_to_back();
      test_reset_mid();
      test_wide_toggle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
